// File: rtl/auth_pkg.sv
// Shared constants for the USB Type-C Authentication responder: message geometry,
// MessageType / error codes, FSM encoding and a header builder.
package auth_pkg;

  localparam int MSG_LEN   = 2080;
  localparam int HDR_W     = 64;
  localparam int PAYLOAD_W = MSG_LEN - HDR_W;

  // Header field LSB positions within a full message (MSB first).
  localparam int VER_LSB  = MSG_LEN - 8;
  localparam int TYPE_LSB = MSG_LEN - 16;
  localparam int P1_LSB   = MSG_LEN - 24;
  localparam int P2_LSB   = MSG_LEN - 32;

  localparam logic [7:0] AUTH_VERSION = 8'h01;

  localparam logic [7:0] MT_GET_DIGESTS     = 8'h81;
  localparam logic [7:0] MT_GET_CERTIFICATE = 8'h82;
  localparam logic [7:0] MT_CHALLENGE       = 8'h83;
  localparam logic [7:0] MT_DIGESTS         = 8'h01;
  localparam logic [7:0] MT_CERTIFICATE     = 8'h02;
  localparam logic [7:0] MT_CHALLENGE_AUTH  = 8'h03;
  localparam logic [7:0] MT_ERROR           = 8'h7F;

  localparam logic [7:0] ERR_INVALID_REQUEST     = 8'h01;
  localparam logic [7:0] ERR_UNSUPPORTED_REQUEST = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_FETCH,
    ST_SEND,
    ST_RETRY,
    ST_RELEASE
  } state_t;

  function automatic logic [HDR_W-1:0] build_header(input logic [7:0] mtype,
                                                    input logic [7:0] param1,
                                                    input logic [7:0] param2,
                                                    input logic [15:0] length);
    return {AUTH_VERSION, mtype, param1, param2, 16'h0000, length};
  endfunction

endpackage

// File: rtl/auth_ack_timer.sv
// Ack timeout counter and retry counter for the response transmitter.
// The timeout counter runs only while run is high and restarts on expiry.
module auth_ack_timer #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  input  logic retry,
  output logic expire,
  output logic exhausted
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  logic [CNT_W-1:0] cnt;
  logic [RTY_W-1:0] retry_cnt;

  assign expire    = run && (cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign exhausted = (retry_cnt == RTY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      retry_cnt <= '0;
    end else begin
      if (!run || expire) cnt <= '0;
      else                cnt <= cnt + CNT_W'(1);

      if (clear)      retry_cnt <= '0;
      else if (retry) retry_cnt <= retry_cnt + RTY_W'(1);
    end
  end

endmodule

// File: rtl/auth_resp_tx.sv
// Driver-side Authentication responder: latches a host request, decodes it,
// fetches the payload from the engine and transmits the response with ack/retry.
module auth_resp_tx
  import auth_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 resp_req_in,
  output logic                 resp_req_out,
  input  logic [MSG_LEN-1:0]   auth_msg_in,
  output logic [MSG_LEN-1:0]   auth_msg_out,
  output logic                 auth_msg_ready,
  input  logic                 Ack_in_driver,
  output logic                 PD_in_ready,
  output logic                 payload_req,
  output logic [7:0]           payload_type,
  output logic [15:0]          payload_param,
  input  logic                 payload_valid,
  input  logic [15:0]          payload_len,
  input  logic [PAYLOAD_W-1:0] payload_data,
  output logic                 tx_fail
);

  state_t     state, state_next;
  logic       armed;
  logic [7:0] req_ver, req_type, req_p1, req_p2;

  logic       accept, fetch, build_err, build_ok, retry, fail, clear;
  logic [7:0] err_code;
  logic       expire, exhausted;

  // Only the first four header bytes drive any decision.
  logic unused_req;
  assign unused_req = ^auth_msg_in[P2_LSB-1:0];

  auth_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .run      (state == ST_SEND),
    .clear    (clear),
    .retry    (retry),
    .expire   (expire),
    .exhausted(exhausted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fetch      = 1'b0;
    build_err  = 1'b0;
    build_ok   = 1'b0;
    retry      = 1'b0;
    fail       = 1'b0;
    clear      = 1'b0;
    err_code   = ERR_INVALID_REQUEST;
    case (state)
      ST_IDLE: begin
        if (resp_req_in && armed) begin
          accept     = 1'b1;
          state_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (req_ver != AUTH_VERSION) begin
          build_err  = 1'b1;
          clear      = 1'b1;
          state_next = ST_SEND;
        end else if (req_type inside {MT_GET_DIGESTS, MT_GET_CERTIFICATE, MT_CHALLENGE}) begin
          fetch      = 1'b1;
          state_next = ST_FETCH;
        end else begin
          build_err  = 1'b1;
          err_code   = ERR_UNSUPPORTED_REQUEST;
          clear      = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_FETCH: begin
        if (payload_valid) begin
          build_ok   = 1'b1;
          clear      = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        // An ack arriving on the expiry cycle still completes the transfer.
        if (Ack_in_driver) begin
          state_next = ST_RELEASE;
        end else if (expire) begin
          if (exhausted) begin
            fail       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            retry      = 1'b1;
            state_next = ST_RETRY;
          end
        end
      end
      ST_RETRY: state_next = ST_SEND;
      ST_RELEASE: begin
        if (!Ack_in_driver) begin
          clear      = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed        <= 1'b1;
      req_ver      <= '0;
      req_type     <= '0;
      req_p1       <= '0;
      req_p2       <= '0;
      auth_msg_out <= '0;
      resp_req_out <= 1'b0;
      payload_req  <= 1'b0;
      tx_fail      <= 1'b0;
    end else begin
      resp_req_out <= accept;
      payload_req  <= fetch;
      tx_fail      <= fail;

      // A level left high must drop before another request can be taken.
      if (accept) begin
        armed    <= 1'b0;
        req_ver  <= auth_msg_in[VER_LSB +: 8];
        req_type <= auth_msg_in[TYPE_LSB +: 8];
        req_p1   <= auth_msg_in[P1_LSB +: 8];
        req_p2   <= auth_msg_in[P2_LSB +: 8];
      end else if (!resp_req_in) begin
        armed <= 1'b1;
      end

      if (build_err)
        auth_msg_out <= {build_header(MT_ERROR, err_code, 8'h00, 16'h0000), {PAYLOAD_W{1'b0}}};
      else if (build_ok)
        auth_msg_out <= {build_header({1'b0, req_type[6:0]}, req_p1, req_p2, payload_len), payload_data};
    end
  end

  assign auth_msg_ready = (state == ST_SEND);
  assign PD_in_ready    = (state == ST_IDLE) && armed;
  assign payload_type   = req_type;
  assign payload_param  = {req_p1, req_p2};

endmodule

// File: tb/tb_auth_resp_tx.sv
// Directed bench for auth_resp_tx: normal fetch, error responses, ack timeout with
// retries, held request level, and reset during SEND.
module tb_auth_resp_tx;

  localparam int MSG_LEN     = 2080;
  localparam int PW          = 2016;
  localparam int ACK_TIMEOUT = 1024;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               resp_req_in = 1'b0;
  logic               resp_req_out;
  logic [MSG_LEN-1:0] auth_msg_in = '0;
  logic [MSG_LEN-1:0] auth_msg_out;
  logic               auth_msg_ready;
  logic               Ack_in_driver = 1'b0;
  logic               PD_in_ready;
  logic               payload_req;
  logic [7:0]         payload_type;
  logic [15:0]        payload_param;
  logic               payload_valid = 1'b0;
  logic [15:0]        payload_len = '0;
  logic [PW-1:0]      payload_data = '0;
  logic               tx_fail;

  int n_checks = 0;
  int n_fail = 0;
  int req_pulses = 0;
  logic [PW-1:0] pay_a, pay_b;

  auth_resp_tx dut (
    .clk           (clk),
    .reset         (reset),
    .resp_req_in   (resp_req_in),
    .resp_req_out  (resp_req_out),
    .auth_msg_in   (auth_msg_in),
    .auth_msg_out  (auth_msg_out),
    .auth_msg_ready(auth_msg_ready),
    .Ack_in_driver (Ack_in_driver),
    .PD_in_ready   (PD_in_ready),
    .payload_req   (payload_req),
    .payload_type  (payload_type),
    .payload_param (payload_param),
    .payload_valid (payload_valid),
    .payload_len   (payload_len),
    .payload_data  (payload_data),
    .tx_fail       (tx_fail)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    if (resp_req_out === 1'b1) req_pulses++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fold32(input logic [PW-1:0] v);
    logic [31:0] f = '0;
    for (int i = 0; i < PW / 32; i++) f ^= v[i*32 +: 32];
    return f;
  endfunction

  task automatic chk_msg(input string tag, input logic [63:0] exp_hdr, input logic [PW-1:0] exp_pay);
    chk({tag, ".hdr"}, auth_msg_out[MSG_LEN-1 -: 64], exp_hdr);
    n_checks++;
    assert (auth_msg_out[PW-1:0] === exp_pay)
    else begin
      n_fail++;
      $error("FAIL %s.payload: observed low %h fold %h expected low %h fold %h", tag,
             auth_msg_out[31:0], fold32(auth_msg_out[PW-1:0]), exp_pay[31:0], fold32(exp_pay));
    end
  endtask

  task automatic set_req(input logic [31:0] hdr);
    auth_msg_in = '0;
    auth_msg_in[MSG_LEN-1 -: 32] = hdr;
    resp_req_in = 1'b1;
  endtask

  task automatic ack_release(input string tag);
    Ack_in_driver = 1'b1;
    step();
    chk({tag, ".ready_drop"}, 64'(auth_msg_ready), 64'h0);
    Ack_in_driver = 1'b0;
    step();
    chk({tag, ".pd_ready_back"}, 64'(PD_in_ready), 64'h1);
  endtask

  initial begin
    int hi;
    int p0;
    for (int i = 0; i < PW / 32; i++) begin
      pay_a[i*32 +: 32] = 32'hA5C3_0000 + 32'(i);
      pay_b[i*32 +: 32] = 32'h1234_5678 ^ (32'(i) * 32'h0101_0101);
    end

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b1;
    step();
    chk("rst.pd_ready", 64'(PD_in_ready), 64'h1);
    chk("rst.ready", 64'(auth_msg_ready), 64'h0);
    chk("rst.resp_req_out", 64'(resp_req_out), 64'h0);
    chk("rst.tx_fail", 64'(tx_fail), 64'h0);
    chk("rst.payload_req", 64'(payload_req), 64'h0);
    chk("rst.msg_hdr", auth_msg_out[MSG_LEN-1 -: 64], 64'h0);

    // Normal GET_CERTIFICATE
    set_req(32'h0182_0000);
    step();
    chk("t1.resp_req_out", 64'(resp_req_out), 64'h1);
    chk("t1.pd_busy", 64'(PD_in_ready), 64'h0);
    resp_req_in = 1'b0;
    step();
    chk("t1.resp_pulse_end", 64'(resp_req_out), 64'h0);
    chk("t1.payload_req", 64'(payload_req), 64'h1);
    chk("t1.payload_type", 64'(payload_type), 64'h82);
    chk("t1.payload_param", 64'(payload_param), 64'h0000);
    payload_valid = 1'b1;
    payload_len   = 16'h0103;
    payload_data  = pay_a;
    step();
    payload_valid = 1'b0;
    chk("t1.payload_req_end", 64'(payload_req), 64'h0);
    chk("t1.ready", 64'(auth_msg_ready), 64'h1);
    chk_msg("t1.msg", 64'h0102_0000_0000_0103, pay_a);
    step();
    chk("t1.ready_hold", 64'(auth_msg_ready), 64'h1);
    Ack_in_driver = 1'b1;
    step();
    chk("t1.ready_drop", 64'(auth_msg_ready), 64'h0);
    chk("t1.pd_release", 64'(PD_in_ready), 64'h0);
    Ack_in_driver = 1'b0;
    step();
    chk("t1.pd_ready_back", 64'(PD_in_ready), 64'h1);
    chk("t1.req_pulses", 64'(req_pulses), 64'h1);

    // Bad version -> InvalidRequest, no engine request
    set_req(32'h0281_0000);
    step();
    chk("t2.resp_req_out", 64'(resp_req_out), 64'h1);
    resp_req_in = 1'b0;
    step();
    chk("t2.no_payload_req", 64'(payload_req), 64'h0);
    chk("t2.ready", 64'(auth_msg_ready), 64'h1);
    chk_msg("t2.msg", 64'h017F_0100_0000_0000, '0);
    ack_release("t2");

    // Unsupported type -> UnsupportedRequest
    set_req(32'h0190_0000);
    step();
    resp_req_in = 1'b0;
    step();
    chk("t3.ready", 64'(auth_msg_ready), 64'h1);
    chk_msg("t3.msg", 64'h017F_0200_0000_0000, '0);
    ack_release("t3");

    // Stray ack / payload_valid in IDLE are ignored
    Ack_in_driver = 1'b1;
    payload_valid = 1'b1;
    step();
    chk("stray.ready", 64'(auth_msg_ready), 64'h0);
    chk("stray.msg_hdr", auth_msg_out[MSG_LEN-1 -: 64], 64'h017F_0200_0000_0000);
    chk("stray.pd_ready", 64'(PD_in_ready), 64'h1);
    Ack_in_driver = 1'b0;
    payload_valid = 1'b0;

    // No ack: three retries then tx_fail
    set_req(32'h0190_0000);
    step();
    resp_req_in = 1'b0;
    step();
    for (int r = 0; r < 4; r++) begin
      hi = 0;
      while (auth_msg_ready === 1'b1 && hi < 2 * ACK_TIMEOUT) begin
        hi++;
        step();
      end
      chk($sformatf("t4.send_len%0d", r), 64'(hi), 64'(ACK_TIMEOUT));
      if (r < 3) begin
        chk($sformatf("t4.retry_low%0d", r), 64'(auth_msg_ready), 64'h0);
        chk($sformatf("t4.no_fail%0d", r), 64'(tx_fail), 64'h0);
        step();
      end else begin
        chk("t4.tx_fail", 64'(tx_fail), 64'h1);
        chk("t4.idle", 64'(PD_in_ready), 64'h1);
        step();
        chk("t4.tx_fail_pulse", 64'(tx_fail), 64'h0);
      end
    end

    // Request level held across a whole transfer
    p0 = req_pulses;
    set_req(32'h0190_0000);
    step();
    chk("t5.resp_req_out", 64'(resp_req_out), 64'h1);
    step();
    Ack_in_driver = 1'b1;
    step();
    Ack_in_driver = 1'b0;
    repeat (3) step();
    chk("t5.not_armed", 64'(PD_in_ready), 64'h0);
    chk("t5.one_pulse", 64'(req_pulses - p0), 64'h1);
    resp_req_in = 1'b0;
    step();
    chk("t5.rearmed", 64'(PD_in_ready), 64'h1);
    set_req(32'h0183_5AC3);
    step();
    chk("t5.second_req", 64'(resp_req_out), 64'h1);
    resp_req_in = 1'b0;
    step();
    chk("t5.payload_req", 64'(payload_req), 64'h1);
    chk("t5.payload_type", 64'(payload_type), 64'h83);
    chk("t5.payload_param", 64'(payload_param), 64'h5AC3);
    payload_valid = 1'b1;
    payload_len   = 16'h0040;
    payload_data  = pay_b;
    step();
    payload_valid = 1'b0;
    chk("t5.ready", 64'(auth_msg_ready), 64'h1);
    chk_msg("t5.msg", 64'h0103_5AC3_0000_0040, pay_b);

    // Reset asserted while in SEND
    reset = 1'b0;
    #1;
    chk("t6.ready", 64'(auth_msg_ready), 64'h0);
    chk("t6.resp_req_out", 64'(resp_req_out), 64'h0);
    chk("t6.tx_fail", 64'(tx_fail), 64'h0);
    chk("t6.msg_hdr", auth_msg_out[MSG_LEN-1 -: 64], 64'h0);
    step();
    reset = 1'b1;
    step();
    chk("t6.pd_ready", 64'(PD_in_ready), 64'h1);
    set_req(32'h0182_0000);
    step();
    chk("t6.resp_req_out2", 64'(resp_req_out), 64'h1);
    resp_req_in = 1'b0;
    step();
    chk("t6.payload_req", 64'(payload_req), 64'h1);
    payload_valid = 1'b1;
    payload_len   = 16'h0011;
    payload_data  = pay_a;
    step();
    payload_valid = 1'b0;
    chk("t6.ready2", 64'(auth_msg_ready), 64'h1);
    chk_msg("t6.msg", 64'h0102_0000_0000_0011, pay_a);
    ack_release("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
